somador_serial_ctrl: RTL and testbench

Sequencer that performs NIBBLES×4-bit addition or subtraction through a single 4-bit ripple-carry adder slice. It processes one nibble per cycle and chains the carry through a register. It sits between a requesting unit and the shared 4-bit adder datapath. It accepts operands on a valid/ready handshake, runs the nibble schedule, and holds the full-width result until the consumer takes it.

---
 rtl/somador_serial_ctrl.sv | 130 +++++++++++++
 tb/tb_somador_serial_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/somador_serial_ctrl.sv
// somador_serial_ctrl
//   Sequencer that adds or subtracts two NIBBLES*4-bit operands through one
//   4-bit ripple-carry slice, one nibble per cycle, LSB nibble first, with
//   the carry between nibbles held in a register.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_valid  operand request valid
//   start_ready  block can accept a request (IDLE only)
//   sub          0 = a+b, 1 = a-b, sampled with the operands
//   a, b         W-bit operands, sampled on the start handshake
//   done_valid   result valid (DONE only)
//   done_ready   consumer accepts the result
//   sum          W-bit result (modulo 2^W)
//   cout         carry out of the MSB; for subtraction 1 = no borrow
//   ovf          signed overflow
//   busy         high in RUN and DONE
module somador_serial_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done_valid,
  input  logic         done_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [KW-1:0] LAST = KW'(NIBBLES - 1);

  state_t        state;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  sum_r;
  logic          c;
  logic          cout_r;
  logic          ovf_r;
  logic [KW-1:0] k;

  logic [KW+1:0] base;
  logic [3:0]    x;
  logic [3:0]    y;
  logic [5:0]    slice;

  // 4-bit ripple-carry slice. Returns {carry out, carry into bit 3, sum}.
  function automatic logic [5:0] slice_add(input logic [3:0] xs,
                                           input logic [3:0] ys,
                                           input logic       cin);
    logic [4:0] cc;
    logic [3:0] s;
    cc[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]    = xs[i] ^ ys[i] ^ cc[i];
      cc[i+1] = (xs[i] & ys[i]) | (xs[i] & cc[i]) | (ys[i] & cc[i]);
    end
    return {cc[4], cc[3], s};
  endfunction

  // Bit offset of the current nibble.
  assign base  = {k, 2'b00};
  assign x     = op_a[base +: 4];
  assign y     = op_b[base +: 4];
  assign slice = slice_add(x, y, c);

  // Handshake/status outputs are pure state decodes, so no input reaches
  // an output combinationally.
  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);
  assign busy        = (state != IDLE);
  assign sum         = sum_r;
  assign cout        = cout_r;
  assign ovf         = ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      sum_r  <= '0;
      c      <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      k      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            op_a   <= a;
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            op_b   <= sub ? ~b : b;
            c      <= sub;
            k      <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_r[base +: 4] <= slice[3:0];
          c                <= slice[5];
          if (k == LAST) begin
            cout_r <= slice[5];
            ovf_r  <= slice[5] ^ slice[4];
            state  <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          if (done_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_somador_serial_ctrl.sv
module tb_somador_serial_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid, start_ready, sub, done_valid, done_ready;
  logic         cout, ovf, busy;
  logic [W-1:0] a, b, sum;

  // Second instance with a single nibble.
  logic         sv1, sr1, sub1, dv1, dr1, cout1, ovf1, busy1;
  logic [3:0]   a1, b1, sum1;

  int tests = 0;
  int fails = 0;

  somador_serial_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .sub(sub), .a(a), .b(b), .done_valid(done_valid), .done_ready(done_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  somador_serial_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
    .sub(sub1), .a(a1), .b(b1), .done_valid(dv1), .done_ready(dr1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on w-bit operands.
  // Returns {ovf, cout, sum[w-1:0]} packed into a 64-bit value (ovf at bit w+1).
  function automatic logic [63:0] model(input logic [63:0] oa, input logic [63:0] ob,
                                        input logic s, input int w);
    logic [63:0] mask, bb, full, rs;
    logic sa, sb, ss, co, ov;
    mask = (64'd1 << w) - 64'd1;
    bb   = s ? (~ob & mask) : (ob & mask);
    full = (oa & mask) + bb + {63'd0, s};
    rs   = full & mask;
    co   = full[w];
    sa   = oa[w-1];
    sb   = ob[w-1];
    ss   = rs[w-1];
    ov   = s ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    return rs | ({63'd0, co} << w) | ({63'd0, ov} << (w + 1));
  endfunction

  // Handshake a request at the next edge; called at a negedge in IDLE.
  task automatic start_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic s);
    tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL start_ready_idle got=%b exp=1", start_ready); end
    a = oa; b = ob; sub = s; start_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    start_valid = 1'b0;
    // Scramble operands: the block must not look at them after the handshake.
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    tests++; if (busy !== 1'b1 || start_ready !== 1'b0 || done_valid !== 1'b0) begin
      fails++; $display("FAIL accept_state busy=%b start_ready=%b done_valid=%b exp 1/0/0", busy, start_ready, done_valid); end
    tests++; if (sum !== '0) begin fails++; $display("FAIL sum_cleared got=%h exp=0", sum); end
  endtask

  // Follow the nibble schedule; ends at the negedge where done_valid is high.
  task automatic collect(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic s);
    logic [63:0] r;
    logic [W-1:0] exp_sum, m;
    r = model({48'd0, oa}, {48'd0, ob}, s, W);
    exp_sum = r[W-1:0];
    for (int j = 1; j <= N; j++) begin
      @(negedge clk);
      if (j < N) begin
        m = '0;
        for (int i = 0; i < 4 * j; i++) m[i] = 1'b1;
        tests++; if (done_valid !== 1'b0 || sum !== (exp_sum & m)) begin
          fails++; $display("FAIL partial_sum_%0d dv=%b got=%h exp=%h", j, done_valid, sum, exp_sum & m); end
      end
    end
    tests++; if (done_valid !== 1'b1) begin fails++; $display("FAIL latency done_valid=%b exp=1 after %0d cycles", done_valid, N); end
    tests++; if (sum !== exp_sum || cout !== r[W] || ovf !== r[W+1]) begin
      fails++; $display("FAIL result %h%s%h sub=%b got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                        oa, s ? "-" : "+", ob, s, sum, cout, ovf, exp_sum, r[W], r[W+1]); end
  endtask

  task automatic accept;
    done_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    done_ready = 1'b0;
    tests++; if (done_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL back_to_idle dv=%b sr=%b busy=%b exp 0/1/0", done_valid, start_ready, busy); end
  endtask

  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic s);
    start_op(oa, ob, s);
    collect(oa, ob, s);
    accept();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
    sv1 = 1'b0; dr1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    #3;
    tests++; if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0 || done_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      fails++; $display("FAIL reset_outputs sum=%h cout=%b ovf=%b dv=%b busy=%b sr=%b", sum, cout, ovf, done_valid, busy, start_ready); end
    tests++; if (sum1 !== '0 || dv1 !== 1'b0 || busy1 !== 1'b0 || sr1 !== 1'b1) begin
      fails++; $display("FAIL reset_outputs_n1 sum=%h dv=%b busy=%b sr=%b", sum1, dv1, busy1, sr1); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    do_op(16'h1234, 16'h0FCD, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1);
    do_op(16'h7FFF, 16'h0001, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1);
    do_op(16'h0000, 16'h0000, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++) do_op(W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] na, nb, held;
    logic ns;
    start_op(16'h4321, 16'h1111, 1'b0);
    collect(16'h4321, 16'h1111, 1'b0);
    held = sum;
    na = W'($urandom); nb = W'($urandom); ns = 1'($urandom);
    a = na; b = nb; sub = ns; start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (done_valid !== 1'b1 || start_ready !== 1'b0 || sum !== held) begin
        fails++; $display("FAIL backpressure_%0d dv=%b sr=%b sum=%h exp 1/0/%h", i, done_valid, start_ready, sum, held); end
    end
    done_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    done_ready = 1'b0;
    tests++; if (done_valid !== 1'b0 || start_ready !== 1'b1 || sum !== held) begin
      fails++; $display("FAIL release dv=%b sr=%b sum=%h exp 0/1/%h", done_valid, start_ready, sum, held); end
    @(posedge clk); @(negedge clk);
    start_valid = 1'b0;
    tests++; if (busy !== 1'b1 || sum !== '0) begin
      fails++; $display("FAIL held_request_accept busy=%b sum=%h exp 1/0", busy, sum); end
    collect(na, nb, ns);
    accept();
    // Issue immediately after the IDLE return: minimum interval.
    do_op(16'h0F0F, 16'hF0F1, 1'b0);
    do_op(16'h0001, 16'h0002, 1'b1);
  endtask

  task automatic test_reset_mid_run;
    start_op(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk); @(posedge clk);   // E1, E2
    #2 rst_n = 1'b0;
    #1;
    tests++; if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0 || done_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      fails++; $display("FAIL reset_mid_run sum=%h cout=%b ovf=%b dv=%b busy=%b sr=%b", sum, cout, ovf, done_valid, busy, start_ready); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b0 || done_valid !== 1'b0) begin
      fails++; $display("FAIL not_resumed busy=%b dv=%b exp 0/0", busy, done_valid); end
    do_op(16'h0001, 16'h0001, 1'b0);
  endtask

  task automatic test_single_nibble;
    logic [63:0] r;
    logic [3:0] ta, tb_;
    logic ts;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin ta = 4'hF; tb_ = 4'h1; ts = 1'b0; end
      else if (i == 1) begin ta = 4'h7; tb_ = 4'h1; ts = 1'b0; end
      else if (i == 2) begin ta = 4'h2; tb_ = 4'h3; ts = 1'b1; end
      else begin ta = 4'($urandom); tb_ = 4'($urandom); ts = 1'($urandom); end
      r = model({60'd0, ta}, {60'd0, tb_}, ts, 4);
      a1 = ta; b1 = tb_; sub1 = ts; sv1 = 1'b1;
      @(posedge clk); @(negedge clk);
      sv1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom); sub1 = 1'($urandom);
      tests++; if (dv1 !== 1'b0 || busy1 !== 1'b1) begin
        fails++; $display("FAIL n1_run_%0d dv=%b busy=%b exp 0/1", i, dv1, busy1); end
      @(negedge clk);
      tests++; if (dv1 !== 1'b1 || sum1 !== r[3:0] || cout1 !== r[4] || ovf1 !== r[5]) begin
        fails++; $display("FAIL n1_result_%0d dv=%b sum=%h cout=%b ovf=%b exp 1/%h/%b/%b", i, dv1, sum1, cout1, ovf1, r[3:0], r[4], r[5]); end
      dr1 = 1'b1;
      @(posedge clk); @(negedge clk);
      dr1 = 1'b0;
      tests++; if (sr1 !== 1'b1 || dv1 !== 1'b0) begin
        fails++; $display("FAIL n1_idle_%0d sr=%b dv=%b exp 1/0", i, sr1, dv1); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_single_nibble();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
